// File: rtl/sprite_mover.sv
// Moves a sprite's top-left corner one step per frame from four push buttons,
// with a slow start that switches to fast motion after the buttons are held for a while.
module sprite_mover #(
    parameter int SPRITE_W    = 64,
    parameter int SPRITE_H    = 64,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int X0          = 288,
    parameter int Y0          = 208,
    parameter int SLOW_STEP   = 1,
    parameter int FAST_STEP   = 4,
    parameter int HOLD_FRAMES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [9:0] posx,
    output logic [9:0] posy,
    output logic       moving
);

    localparam int              CNT_W  = $clog2(HOLD_FRAMES) + 1;
    localparam logic [10:0]     X_MAX  = 11'(SCREEN_W - SPRITE_W);
    localparam logic [10:0]     Y_MAX  = 11'(SCREEN_H - SPRITE_H);
    localparam logic [10:0]     SLOW_S = 11'(SLOW_STEP);
    localparam logic [10:0]     FAST_S = 11'(FAST_STEP);
    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_FRAMES);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

    // Bit order of the synchronizer vectors: {up, down, left, right}.
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       posx_q, posx_d;
    logic [9:0]       posy_q, posy_d;
    logic             moving_q, moving_d;

    logic        up_s, down_s, left_s, right_s;
    logic        active;
    logic [10:0] step;

    // Widened to 11 bits so neither the subtract nor the add can wrap.
    function automatic logic [9:0] move_axis(input logic [9:0] pos, input logic dec,
                                             input logic inc, input logic [10:0] stp,
                                             input logic [10:0] max_pos);
        logic [10:0] wide;
        logic [10:0] res;
        wide = {1'b0, pos};
        res  = wide;
        if (dec && !inc) begin
            res = (wide < stp) ? 11'd0 : wide - stp;
        end else if (inc && !dec) begin
            res = wide + stp;
            if (res > max_pos) res = max_pos;
        end
        return res[9:0];
    endfunction

    assign up_s    = sync2_q[3];
    assign down_s  = sync2_q[2];
    assign left_s  = sync2_q[1];
    assign right_s = sync2_q[0];
    assign active  = (left_s ^ right_s) | (up_s ^ down_s);
    assign step    = (state_q == FAST) ? FAST_S : SLOW_S;

    always_comb begin
        sync1_d  = {btn_up, btn_down, btn_left, btn_right};
        sync2_d  = sync1_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        posx_d   = posx_q;
        posy_d   = posy_q;
        if (frame_tick) begin
            if (!active) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                posx_d = move_axis(posx_q, left_s, right_s, step, X_MAX);
                posy_d = move_axis(posy_q, up_s, down_s, step, Y_MAX);
                case (state_q)
                    IDLE: begin
                        cnt_d   = ONE_C;
                        state_d = (ONE_C == HOLD_C) ? FAST : SLOW;
                    end
                    SLOW: begin
                        cnt_d = cnt_q + ONE_C;
                        if (cnt_d == HOLD_C) state_d = FAST;
                    end
                    default: begin
                        state_d = FAST;
                        cnt_d   = cnt_q;
                    end
                endcase
            end
        end
        moving_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            posx_q   <= 10'(X0);
            posy_q   <= 10'(Y0);
            moving_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            posx_q   <= posx_d;
            posy_q   <= posy_d;
            moving_q <= moving_d;
        end
    end

    assign posx   = posx_q;
    assign posy   = posy_q;
    assign moving = moving_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: a fixed vector table, an independent position model feeding an
// expected queue, and hand-written edge, reset and button-timing sequences.
module tb_sprite_mover;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [9:0] posx, posy;
    logic       moving;

    sprite_mover dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .posx      (posx),
        .posy      (posy),
        .moving    (moving)
    );

    always #5 clk = ~clk;

    // Expected entries are {posx, posy, moving}.
    logic [20:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: position, 0/1/2 = idle/slow/fast, hold count.
    int mx, my, mst, mcnt;

    typedef struct {
        logic       up, down, left, right;
        logic [9:0] ex, ey;
        logic       em;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got x=%0d y=%0d moving=%0d, expected x=%0d y=%0d moving=%0d",
                      name, act[20:11], act[10:1], act[0], exp[20:11], exp[10:1], exp[0]);
    endtask

    task automatic model_reset();
        mx = 288; my = 208; mst = 0; mcnt = 0;
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_push();
        int dx, dy, stp;
        dx = int'(btn_right) - int'(btn_left);
        dy = int'(btn_down) - int'(btn_up);
        if (dx == 0 && dy == 0) begin
            mst = 0; mcnt = 0;
        end else begin
            stp = (mst == 2) ? 4 : 1;
            mx = clampi(mx + dx * stp, 576);
            my = clampi(my + dy * stp, 416);
            if (mst == 0) begin
                mst = 1; mcnt = 1;
            end else if (mst == 1) begin
                mcnt++;
                if (mcnt == 16) mst = 2;
            end
        end
        exp_q.push_back({10'(mx), 10'(my), 1'(mst != 0)});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        exp_q.delete();
    endtask

    task automatic set_btns(input logic u, input logic d, input logic l, input logic r);
        @(negedge clk);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_tick(input string name);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: got no expected entry, required one queued", name);
        end else begin
            check(name, {posx, posy, moving}, exp_q.pop_front());
        end
    endtask

    task automatic model_ticks(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            model_push();
            do_tick(name);
        end
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 10'd289, 10'd208, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 10'd290, 10'd208, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 10'd291, 10'd208, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 10'd291, 10'd209, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 10'd291, 10'd209, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 10'd290, 10'd208, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 10'd291, 10'd209, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd291, 10'd209, 1'b0};

        do_reset();
        @(negedge clk);
        check("reset_state", {posx, posy, moving}, {10'd288, 10'd208, 1'b0});

        for (int i = 0; i < 8; i++) begin
            set_btns(tbl[i].up, tbl[i].down, tbl[i].left, tbl[i].right);
            exp_q.push_back({tbl[i].ex, tbl[i].ey, tbl[i].em});
            do_tick($sformatf("table_%0d", i));
        end

        // Slow-to-fast switch after sixteen held frames, then release.
        do_reset();
        set_btns(1'b0, 1'b0, 1'b1, 1'b0);
        model_ticks(16, "left_slow");
        check("left_16", {posx, posy, moving}, {10'd272, 10'd208, 1'b1});
        model_ticks(4, "left_fast");
        check("left_20", {posx, posy, moving}, {10'd256, 10'd208, 1'b1});
        set_btns(1'b0, 1'b0, 1'b0, 1'b0);
        model_ticks(1, "release");
        check("release_idle", {posx, posy, moving}, {10'd256, 10'd208, 1'b0});

        // Left edge clamp from x=2 while fast.
        do_reset();
        set_btns(1'b0, 1'b0, 1'b0, 1'b1);
        model_ticks(2, "pre_right");
        set_btns(1'b0, 1'b0, 1'b0, 1'b0);
        model_ticks(1, "pre_idle");
        set_btns(1'b0, 1'b0, 1'b1, 1'b0);
        model_ticks(84, "to_left_edge");
        check("at_x2", {posx, posy, moving}, {10'd2, 10'd208, 1'b1});
        model_ticks(1, "clamp_left");
        check("clamp_x0", {posx, posy, moving}, {10'd0, 10'd208, 1'b1});
        model_ticks(2, "hold_left_edge");
        check("stay_x0", {posx, posy, moving}, {10'd0, 10'd208, 1'b1});

        // Right edge clamp from x=574, then drive down into the corner.
        do_reset();
        set_btns(1'b0, 1'b0, 1'b1, 1'b0);
        model_ticks(2, "pre_left");
        set_btns(1'b0, 1'b0, 1'b0, 1'b0);
        model_ticks(1, "pre_idle2");
        set_btns(1'b0, 1'b0, 1'b0, 1'b1);
        model_ticks(84, "to_right_edge");
        check("at_x574", {posx, posy, moving}, {10'd574, 10'd208, 1'b1});
        model_ticks(1, "clamp_right");
        check("clamp_x576", {posx, posy, moving}, {10'd576, 10'd208, 1'b1});
        set_btns(1'b0, 1'b1, 1'b0, 1'b1);
        model_ticks(53, "to_corner");
        check("corner", {posx, posy, moving}, {10'd576, 10'd416, 1'b1});

        // Reset coinciding with a frame tick wins.
        @(negedge clk);
        rst_n = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("reset_over_tick", {posx, posy, moving}, {10'd288, 10'd208, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        exp_q.delete();

        // A tick right after reset release sees nothing yet; the next one does.
        set_btns(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        btn_right = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("tick_before_sync", {posx, posy, moving}, {10'd288, 10'd208, 1'b0});
        model_reset();
        exp_q.delete();
        model_ticks(1, "tick_after_sync");
        check("first_synced_move", {posx, posy, moving}, {10'd289, 10'd208, 1'b1});

        // Held button without ticks, then a sub-cycle pulse.
        do_reset();
        set_btns(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (1000) @(negedge clk);
        check("no_tick_hold", {posx, posy, moving}, {10'd288, 10'd208, 1'b0});
        set_btns(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 btn_right = 1'b1;
        #2 btn_right = 1'b0;
        repeat (3) @(negedge clk);
        model_ticks(1, "short_pulse");
        check("short_pulse_still", {posx, posy, moving}, {10'd288, 10'd208, 1'b0});

        // Random button patterns against the model.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            set_btns(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            model_ticks(int'($urandom_range(1, 6)), "random");
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL leftover_queue: got %0d entries, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
